// File: rtl/seg_scan_if.sv
// seg_scan_if: control, data and display bundle of the seven-segment scan controller
// master drives enable/digits_in/dp_in/blink_in/lz_en/load and reads load_ack/an_out/seg_out/frame_done;
// slave is the controller side.
interface seg_scan_if #(parameter int NUM_DIGITS = 8);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    lz_en;
    logic                    load;
    logic                    load_ack;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [7:0]              seg_out;
    logic                    frame_done;
    modport master (output enable, digits_in, dp_in, blink_in, lz_en, load,
                    input load_ack, an_out, seg_out, frame_done);
    modport slave  (input enable, digits_in, dp_in, blink_in, lz_en, load,
                    output load_ack, an_out, seg_out, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scanner with shadowed digit data
// clk, reset (async, active-high); bus (seg_scan_if.slave): enable, digits_in, dp_in, blink_in,
// lz_en, load in; load_ack, an_out (one-hot), seg_out {dp,g..a}, frame_done out.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 200000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_FRAMES = 32
) (
    input logic        clk,
    input logic        reset,
    seg_scan_if.slave  bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [FW-1:0]           fcnt;
    logic                    phase, pend;
    logic [4*NUM_DIGITS-1:0] sh_dig;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blink, an_r;
    logic [7:0]              seg_r, seg_n;
    logic                    fd_r, fd_n, sup, dark;
    logic [3:0]              nib;

    // Outputs are decoded from the next state so that they register on the edge entering it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        if (!bus.enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                BLANK: begin
                    cnt_n   = cnt + CW'(1);
                    state_n = cnt == CW'(BLANK_CYCLES - 1) ? DRIVE : BLANK;
                end
                default: begin
                    if (cnt == CW'(SLOT_CYCLES - 1)) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        idx_n   = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            endcase
        end
        nib = sh_dig[{idx_n, 2'b00} +: 4];
        // Leading zero: this digit and every higher one are zero, i.e. nothing left after shifting.
        sup   = bus.lz_en && idx_n != '0 && (sh_dig >> {idx_n, 2'b00}) == '0;
        dark  = state_n != DRIVE || (phase && sh_blink[idx_n]);
        seg_n = dark ? 8'h00 : {sh_dp[idx_n], sup ? 7'h00 : SEG_LUT[nib]};
        fd_n  = state_n == DRIVE && cnt_n == CW'(SLOT_CYCLES - 1) && idx_n == IW'(NUM_DIGITS - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            phase    <= 1'b0;
            pend     <= 1'b0;
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
            an_r     <= '0;
            seg_r    <= '0;
            fd_r     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            an_r  <= state_n == DRIVE ? NUM_DIGITS'(1) << idx_n : '0;
            seg_r <= seg_n;
            fd_r  <= fd_n;
            // fd_r marks the frame-boundary cycle itself; a load seen there is consumed immediately.
            pend  <= !fd_r && (pend || bus.load);
            if (fd_r) begin
                fcnt  <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + FW'(1);
                phase <= phase ^ (fcnt == FW'(BLINK_FRAMES - 1));
                if (pend || bus.load) begin
                    sh_dig   <= bus.digits_in;
                    sh_dp    <= bus.dp_in;
                    sh_blink <= bus.blink_in;
                end
            end
        end
    end

    assign bus.an_out     = an_r;
    assign bus.seg_out    = seg_r;
    assign bus.frame_done = fd_r;
    assign bus.load_ack   = fd_r & (pend | bus.load);
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (4 digits, 10-cycle slots)
module tb_seg_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(10), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic disp(input string tag, input logic [3:0] an, input logic [7:0] seg);
        check({tag, "_an"}, bus.an_out, an);
        check({tag, "_seg"}, bus.seg_out, seg);
    endtask

    // Steps until frame_done; the step count doubles as the period check and bounds the wait.
    task automatic wait_fd(input string tag, input int exp_n);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.frame_done && n < 100);
        check(tag, n, exp_n);
    endtask

    logic [7:0] blink_exp [4] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    int seen;

    initial begin
        bus.enable = 1'b0;
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.blink_in = '0;
        bus.lz_en = 1'b0;
        bus.load = 1'b0;
        step(2);
        disp("rst", 4'h0, 8'h00);
        check("rst_ack", bus.load_ack, 0);
        check("rst_fd", bus.frame_done, 0);
        reset = 1'b0;

        bus.enable = 1'b1;
        bus.digits_in = 16'h4321;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        disp("t1_blank", 4'h0, 8'h00);
        step(2);
        disp("t1_f0_d0", 4'h1, 8'h3F);
        wait_fd("t1_fd1_n", 37);
        check("t1_ack1", bus.load_ack, 1);
        step(1);
        disp("t1_b0", 4'h0, 8'h00);
        step(1);
        disp("t1_b1", 4'h0, 8'h00);
        step(1);
        disp("t1_d0", 4'h1, 8'h06);
        step(13);
        disp("t1_d1", 4'h2, 8'h5B);
        wait_fd("t1_fd2_n", 24);
        check("t1_noack", bus.load_ack, 0);

        bus.digits_in = 16'h0042;
        bus.lz_en = 1'b1;
        bus.load = 1'b1;
        #1;
        check("t2_ack_same", bus.load_ack, 1);
        step(1);
        bus.load = 1'b0;
        step(2);
        disp("t2_d0", 4'h1, 8'h5B);
        step(10);
        disp("t2_d1", 4'h2, 8'h66);
        step(10);
        disp("t2_d2", 4'h4, 8'h00);
        step(10);
        disp("t2_d3", 4'h8, 8'h00);
        wait_fd("t2_fd3_n", 7);
        bus.digits_in = 16'h0000;
        bus.load = 1'b1;
        #1;
        check("t2_ack0", bus.load_ack, 1);
        step(1);
        bus.load = 1'b0;
        step(2);
        disp("t2_z_d0", 4'h1, 8'h3F);
        step(10);
        disp("t2_z_d1", 4'h2, 8'h00);
        wait_fd("t2_fd4_n", 27);
        check("t3_noack", bus.load_ack, 0);

        step(6);
        bus.digits_in = 16'h1111;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        disp("t3_c6", 4'h1, 8'h3F);
        step(9);
        disp("t3_c15", 4'h2, 8'h00);
        bus.digits_in = 16'h8888;
        bus.dp_in = 4'b0010;
        bus.blink_in = 4'b0010;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(9);
        disp("t3_c25", 4'h4, 8'h00);
        wait_fd("t3_fd5_n", 14);
        check("t3_ack", bus.load_ack, 1);
        bus.lz_en = 1'b0;

        for (int f = 0; f < 4; f++) begin
            step(3);
            disp($sformatf("t4_f%0d_d0", f), 4'h1, 8'h7F);
            step(10);
            disp($sformatf("t4_f%0d_d1", f), 4'h2, blink_exp[f]);
            wait_fd($sformatf("t4_f%0d_n", f), 27);
        end

        step(25);
        disp("t5_d2", 4'h4, 8'h7F);
        bus.enable = 1'b0;
        step(1);
        disp("t5_off", 4'h0, 8'h00);
        check("t5_off_fd", bus.frame_done, 0);
        seen = 0;
        repeat (50) begin
            step(1);
            seen += int'(bus.frame_done);
        end
        check("t5_no_fd", seen, 0);
        bus.enable = 1'b1;
        step(1);
        disp("t5_re_b0", 4'h0, 8'h00);
        step(1);
        disp("t5_re_b1", 4'h0, 8'h00);
        step(1);
        disp("t5_re_d0", 4'h1, 8'h7F);

        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(1);
        #3;
        reset = 1'b1;
        #1;
        disp("t6_async", 4'h0, 8'h00);
        check("t6_fd", bus.frame_done, 0);
        step(1);
        reset = 1'b0;
        step(3);
        disp("t6_d0", 4'h1, 8'h3F);
        wait_fd("t6_fd_n", 37);
        check("t6_noack", bus.load_ack, 0);
        step(5);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        wait_fd("t6_fd2_n", 34);
        check("t6_newack", bus.load_ack, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
